// File: rtl/fifo_stream_fwft.sv
// Single-clock FWFT stream FIFO: RAM plus a registered output stage,
// empty-path bypass, occupancy count, programmable flags and flush.
module fifo_stream_fwft #(
   parameter int PAYLOAD_BITS      = 32,
   parameter int NUM_ADDR_BITS     = 4,
   parameter int PROG_FULL_THRESH  = 12,
   parameter int PROG_EMPTY_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [PAYLOAD_BITS-1:0]  din,
   input  logic                     val_in,
   output logic                     ready_upward,
   output logic [PAYLOAD_BITS-1:0]  dout,
   output logic                     val_out,
   input  logic                     ready_downward,
   output logic [NUM_ADDR_BITS:0]   count,
   output logic                     prog_full,
   output logic                     prog_empty
);

   localparam int DEPTH = 2 ** NUM_ADDR_BITS;
   localparam int CW    = NUM_ADDR_BITS + 1;
   localparam int AW    = NUM_ADDR_BITS;

   localparam logic [CW-1:0] CAP = CW'(DEPTH + 1);
   localparam logic [CW-1:0] PF  = CW'(PROG_FULL_THRESH);
   localparam logic [CW-1:0] PE  = CW'(PROG_EMPTY_THRESH);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];

   logic [0:0]              state_q, state_d;
   logic [PAYLOAD_BITS-1:0] dout_q, dout_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    prog_full_q, prog_full_d;
   logic                    prog_empty_q, prog_empty_d;

   logic          push, pop, bypass, load, ram_we, ram_empty;
   logic [CW-1:0] ram_cnt;

   assign ready_upward = (count_q < CAP);
   assign val_out      = (state_q == ST_HOLD);
   assign dout         = dout_q;
   assign count        = count_q;
   assign prog_full    = prog_full_q;
   assign prog_empty   = prog_empty_q;

   assign push      = val_in & ready_upward;
   assign pop       = val_out & ready_downward;
   // The output register holds one entry whenever val_out is high
   assign ram_cnt   = count_q - CW'(state_q);
   assign ram_empty = (ram_cnt == '0);

   always_comb begin
      bypass  = 1'b0;
      load    = 1'b0;
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (push && ram_empty) bypass = 1'b1;
            else if (!ram_empty)   load   = 1'b1;
         end
         ST_HOLD: begin
            if (pop) begin
               if (!ram_empty) load    = 1'b1;
               else if (push)  bypass  = 1'b1;
               else            state_d = ST_EMPTY;
            end
         end
         default: ;
      endcase
      if (bypass || load) state_d = ST_HOLD;

      ram_we = push & ~bypass;

      dout_d = dout_q;
      if (bypass)    dout_d = din;
      else if (load) dout_d = mem_q[rd_ptr_q];

      wr_ptr_d = wr_ptr_q + AW'(ram_we);
      rd_ptr_d = rd_ptr_q + AW'(load);

      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      // Flush wins over any push/pop in the same cycle
      if (flush) begin
         ram_we   = 1'b0;
         state_d  = ST_EMPTY;
         dout_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      prog_full_d  = (count_d >= PF);
      prog_empty_d = (count_d <= PE);
   end

   always_ff @(posedge clk) begin
      if (ram_we) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         dout_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         prog_full_q  <= 1'b0;
         prog_empty_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         dout_q       <= dout_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         prog_full_q  <= prog_full_d;
         prog_empty_q <= prog_empty_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_fwft.sv
// Scoreboard bench for fifo_stream_fwft: a plain queue models the FIFO
// contents, monitors compare handshakes and status against it.
`timescale 1ns/1ps
module tb_fifo_stream_fwft;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] din = '0;
   logic        val_in = 1'b0;
   logic        ready_downward = 1'b0;
   logic        ready_upward;
   logic [31:0] dout;
   logic        val_out;
   logic [4:0]  count;
   logic        prog_full;
   logic        prog_empty;

   localparam int CAP = 17;
   localparam int PFT = 12;
   localparam int PET = 2;

   fifo_stream_fwft dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .din            (din),
      .val_in         (val_in),
      .ready_upward   (ready_upward),
      .dout           (dout),
      .val_out        (val_out),
      .ready_downward (ready_downward),
      .count          (count),
      .prog_full      (prog_full),
      .prog_empty     (prog_empty)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] sb[$];
   bit          hold_prev = 1'b0;
   logic [31:0] hold_dout = '0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Input side: record every accepted word in the reference queue
   always @(negedge clk) begin
      if (rst_n) begin
         if (flush) sb.delete();
         else if (val_in && ready_upward) sb.push_back(din);
      end
   end

   // Output side: check popped data and AXI-stream hold stability
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", 32'(val_out), 32'd1);
            chk("hold_data", dout, hold_dout);
         end
         if (val_out && ready_downward) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL pop_unexpected: got %0h expected nothing", dout);
            end else begin
               chk("pop_data", dout, sb[0]);
               void'(sb.pop_front());
            end
         end
         hold_prev = val_out && !ready_downward;
         hold_dout = dout;
      end
   end

   // Status after each edge must match the model occupancy
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("count", 32'(count), 32'(sb.size()));
         chk("ready_up", 32'(ready_upward), 32'(sb.size() < CAP));
         chk("prog_full", 32'(prog_full), 32'(sb.size() >= PFT));
         chk("prog_empty", 32'(prog_empty), 32'(sb.size() <= PET));
         chk("val_out", 32'(val_out), 32'(sb.size() > 0));
         if (sb.size() > 0) chk("head", dout, sb[0]);
      end
   end

   initial begin
      #12;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_val", 32'(val_out), 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_ready", 32'(ready_upward), 32'd1);
      chk("rst_pempty", 32'(prog_empty), 32'd1);
      chk("rst_pfull", 32'(prog_full), 32'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      step();

      // back-to-back through the bypass path
      ready_downward = 1'b1;
      val_in = 1'b1;
      din = 32'h11;
      step();
      chk("t1_lat_val", 32'(val_out), 32'd1);
      chk("t1_d11", dout, 32'h11);
      din = 32'h22;
      step();
      chk("t1_d22", dout, 32'h22);
      din = 32'h33;
      step();
      chk("t1_d33", dout, 32'h33);
      val_in = 1'b0;
      step();
      chk("t1_count0", 32'(count), 32'd0);

      // fill past capacity
      ready_downward = 1'b0;
      for (int i = 0; i < 20; i++) begin
         val_in = 1'b1;
         din = 32'(i);
         step();
      end
      val_in = 1'b0;
      chk("t2_count", 32'(count), 32'd17);
      chk("t2_ready", 32'(ready_upward), 32'd0);
      chk("t2_pfull", 32'(prog_full), 32'd1);
      chk("t2_head", dout, 32'd0);
      ready_downward = 1'b1;
      repeat (20) step();
      chk("t2_drained", 32'(count), 32'd0);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);

      // stall with data held, then random traffic
      ready_downward = 1'b0;
      for (int i = 0; i < 3; i++) begin
         val_in = 1'b1;
         din = 32'hC0 + 32'(i);
         step();
      end
      val_in = 1'b0;
      repeat (5) step();
      for (int c = 0; c < 1000; c++) begin
         int rd_pct;
         rd_pct = ((c / 100) % 2 == 0) ? 30 : 75;
         val_in = 1'($urandom_range(0, 1));
         din = $urandom;
         ready_downward = ($urandom_range(0, 99) < rd_pct);
         flush = ($urandom_range(0, 199) == 0);
         step();
      end
      flush = 1'b0;
      val_in = 1'b0;
      ready_downward = 1'b1;
      repeat (20) step();
      chk("t3_drained", 32'(count), 32'd0);

      // push and pop together with a single entry held
      ready_downward = 1'b0;
      val_in = 1'b1;
      din = 32'hA1;
      step();
      chk("t4_count1", 32'(count), 32'd1);
      din = 32'hB2;
      ready_downward = 1'b1;
      step();
      val_in = 1'b0;
      ready_downward = 1'b0;
      chk("t4_dout", dout, 32'hB2);
      chk("t4_count", 32'(count), 32'd1);
      chk("t4_val", 32'(val_out), 32'd1);
      ready_downward = 1'b1;
      step();

      // flush with a concurrent push
      ready_downward = 1'b0;
      for (int i = 0; i < 9; i++) begin
         val_in = 1'b1;
         din = 32'h100 + 32'(i);
         step();
      end
      chk("t5_count9", 32'(count), 32'd9);
      flush = 1'b1;
      din = 32'hDEAD;
      step();
      flush = 1'b0;
      val_in = 1'b0;
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_val", 32'(val_out), 32'd0);
      chk("t5_ready", 32'(ready_upward), 32'd1);
      chk("t5_pempty", 32'(prog_empty), 32'd1);
      val_in = 1'b1;
      din = 32'hBEEF;
      step();
      val_in = 1'b0;
      chk("t5_after", dout, 32'hBEEF);
      ready_downward = 1'b1;
      repeat (2) step();

      // async reset mid-stream
      ready_downward = 1'b0;
      for (int i = 0; i < 7; i++) begin
         val_in = 1'b1;
         din = 32'h200 + 32'(i);
         step();
      end
      val_in = 1'b0;
      chk("t6_count7", 32'(count), 32'd7);
      @(negedge clk);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("t6_val", 32'(val_out), 32'd0);
      chk("t6_count", 32'(count), 32'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      step();
      val_in = 1'b1;
      din = 32'hA5;
      step();
      val_in = 1'b0;
      chk("t6_a5_val", 32'(val_out), 32'd1);
      chk("t6_a5", dout, 32'hA5);
      ready_downward = 1'b1;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
